// File: rtl/taxi_eth_pkg.sv
// Shared Ethernet receive-path definitions: control FSM state codes,
// the power-on frame length limit and a state decode helper.
package taxi_eth_pkg;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_DISABLED = 2'd0;
    localparam rx_state_t ST_ENABLED  = 2'd1;
    localparam rx_state_t ST_DRAIN    = 2'd2;
    localparam rx_state_t ST_FAULT    = 2'd3;

    localparam logic [15:0] DEF_MAX_PKT_LEN = 16'd1518;

    // Receiver is switched on in both ENABLED and DRAIN
    function automatic logic rx_active(input rx_state_t st);
        return (st == ST_ENABLED) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/taxi_xgmii_rx_ctrl_if.sv
// Config/status bundle between the receive controller and the 64-bit XGMII receiver.
interface taxi_xgmii_rx_ctrl_if;
    logic        cfg_rx_enable;
    logic [15:0] cfg_rx_max_pkt_len;
    logic [1:0]  rx_start_packet;
    logic        stat_rx_pkt_good;
    logic        stat_rx_pkt_bad;

    modport master (
        output cfg_rx_enable, cfg_rx_max_pkt_len,
        input  rx_start_packet, stat_rx_pkt_good, stat_rx_pkt_bad
    );

    modport slave (
        input  cfg_rx_enable, cfg_rx_max_pkt_len,
        output rx_start_packet, stat_rx_pkt_good, stat_rx_pkt_bad
    );
endinterface

// File: rtl/taxi_xgmii_rx_err_mon.sv
// Windowed bad-frame monitor: counts bad frames per 2**WINDOW_W active cycles
// and raises a combinational trip when the count reaches ERR_THRESH.
module taxi_xgmii_rx_err_mon #(
    parameter int unsigned ERR_THRESH = 8,
    parameter int unsigned WINDOW_W   = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic clear,
    input  logic bad,
    output logic trip
);

    logic [WINDOW_W-1:0] win_cnt;
    logic [7:0]          bad_win;
    logic                wrap;
    logic [7:0]          inc_base;
    logic [7:0]          bad_inc;

    assign wrap     = active && (win_cnt == '1);
    // A bad frame on the wrap cycle belongs to the new window
    assign inc_base = wrap ? 8'd0 : bad_win;
    assign bad_inc  = (inc_base == 8'hff) ? 8'hff : inc_base + 8'd1;
    assign trip     = active && bad && (bad_inc >= 8'(ERR_THRESH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            bad_win <= '0;
        end else if (clear) begin
            win_cnt <= '0;
            bad_win <= '0;
        end else if (active) begin
            win_cnt <= win_cnt + WINDOW_W'(1);
            if (bad)
                bad_win <= bad_inc;
            else if (wrap)
                bad_win <= '0;
        end
    end

endmodule

// File: rtl/taxi_xgmii_rx_ctrl.sv
// XGMII receive controller: gates receiver enable/max length from software
// requests at frame boundaries, tracks frame activity, counts frames, trips on error bursts.
module taxi_xgmii_rx_ctrl
    import taxi_eth_pkg::*;
#(
    parameter int unsigned ERR_THRESH = 8,
    parameter int unsigned WINDOW_W   = 24,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sw_rx_enable,
    input  logic [15:0]          sw_max_pkt_len,
    input  logic                 fault_clear,
    input  logic                 cnt_clear,
    taxi_xgmii_rx_ctrl_if.master rx,
    output logic                 rx_busy,
    output logic                 fault,
    output logic [CNT_W-1:0]     good_cnt,
    output logic [CNT_W-1:0]     bad_cnt
);

    rx_state_t   state, state_nxt;
    logic        cfg_en_q;
    logic [15:0] max_len_q;
    logic        busy_nxt, pkt_end, trip, mon_active, mon_clear;

    assign rx.cfg_rx_enable      = cfg_en_q;
    assign rx.cfg_rx_max_pkt_len = max_len_q;

    assign pkt_end    = rx.stat_rx_pkt_good | rx.stat_rx_pkt_bad;
    // A new start in the same cycle as an end keeps the frame open
    assign busy_nxt   = (rx_busy & ~pkt_end) | (|rx.rx_start_packet);
    assign mon_active = rx_active(state);
    assign mon_clear  = fault_clear && (state == ST_FAULT);

    taxi_xgmii_rx_err_mon #(
        .ERR_THRESH (ERR_THRESH),
        .WINDOW_W   (WINDOW_W)
    ) u_err_mon (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (mon_active),
        .clear  (mon_clear),
        .bad    (rx.stat_rx_pkt_bad),
        .trip   (trip)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_DISABLED: if (sw_rx_enable && !rx_busy) state_nxt = ST_ENABLED;
            ST_ENABLED: begin
                if (trip)              state_nxt = ST_FAULT;
                else if (!sw_rx_enable) state_nxt = rx_busy ? ST_DRAIN : ST_DISABLED;
            end
            ST_DRAIN: begin
                if (trip)              state_nxt = ST_FAULT;
                else if (sw_rx_enable) state_nxt = ST_ENABLED;
                else if (!rx_busy)     state_nxt = ST_DISABLED;
            end
            ST_FAULT: if (fault_clear) state_nxt = ST_DISABLED;
            default: state_nxt = ST_DISABLED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_DISABLED;
            cfg_en_q  <= 1'b0;
            max_len_q <= DEF_MAX_PKT_LEN;
            rx_busy   <= 1'b0;
            fault     <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            cfg_en_q <= rx_active(state_nxt);
            fault    <= (state_nxt == ST_FAULT);
            rx_busy  <= busy_nxt;
            // Length only moves while the line is idle now and next cycle
            if (!rx_busy && !busy_nxt)
                max_len_q <= sw_max_pkt_len;
            if (cnt_clear)
                good_cnt <= '0;
            else if (rx.stat_rx_pkt_good)
                good_cnt <= good_cnt + CNT_W'(1);
            if (cnt_clear)
                bad_cnt <= '0;
            else if (rx.stat_rx_pkt_bad)
                bad_cnt <= bad_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_taxi_xgmii_rx_ctrl.sv
// Bench for taxi_xgmii_rx_ctrl: vector table, directed window/fault/reset
// sequences, then random traffic against a cycle-level reference model.
module tb_taxi_xgmii_rx_ctrl;

    localparam int THRESH = 8;
    localparam int WIN_W  = 4;
    localparam int WIN    = 1 << WIN_W;
    localparam int CW     = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en, fclr, cclr, good, bad;
    logic [15:0] len;
    logic [1:0]  start;
    logic        rx_busy, fault;
    logic [CW-1:0] good_cnt, bad_cnt;

    taxi_xgmii_rx_ctrl_if ifc ();
    assign ifc.rx_start_packet  = start;
    assign ifc.stat_rx_pkt_good = good;
    assign ifc.stat_rx_pkt_bad  = bad;

    taxi_xgmii_rx_ctrl #(.ERR_THRESH(THRESH), .WINDOW_W(WIN_W), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sw_rx_enable   (en),
        .sw_max_pkt_len (len),
        .fault_clear    (fclr),
        .cnt_clear      (cclr),
        .rx             (ifc),
        .rx_busy        (rx_busy),
        .fault          (fault),
        .good_cnt       (good_cnt),
        .bad_cnt        (bad_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: mode, frame activity, limits, counters and a
    // bad-event tally keyed by window number of the active-cycle index.
    typedef enum {M_OFF, M_ON, M_DRAIN, M_FAULT} m_st_e;
    m_st_e m_st;
    bit    m_busy;
    int    m_len, m_gc, m_bc, m_act, m_win_id, m_win_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_OFF; m_busy = 0; m_len = 1518;
        m_gc = 0; m_bc = 0; m_act = 0; m_win_id = 0; m_win_bad = 0;
    endtask

    task automatic set_in(input logic e, input int l, input logic fc, input logic cc,
                          input logic [1:0] s, input logic g, input logic b);
        en = e; len = 16'(l); fclr = fc; cclr = cc; start = s; good = g; bad = b;
    endtask

    task automatic cmp_model();
        chk("cfg_rx_enable", 32'(ifc.cfg_rx_enable), 32'(m_st == M_ON || m_st == M_DRAIN));
        chk("cfg_rx_max_pkt_len", 32'(ifc.cfg_rx_max_pkt_len), 32'(m_len));
        chk("rx_busy", 32'(rx_busy), 32'(m_busy));
        chk("fault", 32'(fault), 32'(m_st == M_FAULT));
        chk("good_cnt", 32'(good_cnt), 32'(m_gc));
        chk("bad_cnt", 32'(bad_cnt), 32'(m_bc));
    endtask

    // Advance model with the current inputs, clock once, compare.
    task automatic step();
        bit    on, tripped, nb;
        int    w;
        m_st_e nx;
        on = (m_st == M_ON || m_st == M_DRAIN);
        tripped = 0;
        if (on) begin
            if (bad) begin
                w = (m_act + 1) / WIN;
                if (w != m_win_id) begin m_win_id = w; m_win_bad = 0; end
                if (m_win_bad < 255) m_win_bad++;
                tripped = (m_win_bad >= THRESH);
            end
            m_act++;
        end
        nx = m_st;
        case (m_st)
            M_OFF:   if (en && !m_busy) nx = M_ON;
            M_ON:    if (tripped) nx = M_FAULT; else if (!en) nx = m_busy ? M_DRAIN : M_OFF;
            M_DRAIN: if (tripped) nx = M_FAULT; else if (en) nx = M_ON; else if (!m_busy) nx = M_OFF;
            M_FAULT: if (fclr) begin nx = M_OFF; m_act = 0; m_win_id = 0; m_win_bad = 0; end
        endcase
        nb = (start != 2'b00) || (m_busy && !(good || bad));
        if (!m_busy && !nb) m_len = len;
        if (cclr) begin m_gc = 0; m_bc = 0; end
        else begin
            if (good) m_gc = (m_gc + 1) % (1 << CW);
            if (bad)  m_bc = (m_bc + 1) % (1 << CW);
        end
        m_st = nx; m_busy = nb;
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cfg_en"}, 32'(ifc.cfg_rx_enable), 0);
        chk({tag, "_len"}, 32'(ifc.cfg_rx_max_pkt_len), 1518);
        chk({tag, "_busy"}, 32'(rx_busy), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_good"}, 32'(good_cnt), 0);
        chk({tag, "_bad"}, 32'(bad_cnt), 0);
    endtask

    // Step (with idle enabled inputs) until the active-cycle index hits phase
    task automatic align(input int phase);
        for (int i = 0; i < WIN && (m_act % WIN) != phase; i++) begin
            set_in(1, 1518, 0, 0, 0, 0, 0);
            step();
        end
        chk("align_phase", 32'(m_act % WIN), 32'(phase));
    endtask

    typedef struct {
        logic en; int len; logic fclr, cclr; logic [1:0] start; logic good, bad;
        logic ce; int ml; logic busy, flt; int gc, bc;
    } vec_t;
    vec_t vecs[13];

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk_reset_vals("por");
        rst_n = 1'b1;

        //            en len  fc cc st    g  b    ce ml    bsy f  gc bc
        vecs[0]  = '{1, 9000, 0, 0, 2'b00, 0, 0,  1, 9000, 0,  0, 0, 0};
        vecs[1]  = '{1, 9000, 0, 0, 2'b01, 0, 0,  1, 9000, 1,  0, 0, 0};
        vecs[2]  = '{0, 64,   0, 0, 2'b00, 0, 0,  1, 9000, 1,  0, 0, 0};
        vecs[3]  = '{0, 64,   0, 0, 2'b00, 0, 0,  1, 9000, 1,  0, 0, 0};
        vecs[4]  = '{0, 64,   0, 0, 2'b00, 1, 0,  1, 9000, 0,  0, 1, 0};
        vecs[5]  = '{0, 64,   0, 0, 2'b00, 0, 0,  0, 64,   0,  0, 1, 0};
        vecs[6]  = '{0, 64,   0, 0, 2'b10, 0, 0,  0, 64,   1,  0, 1, 0};
        vecs[7]  = '{0, 64,   0, 0, 2'b10, 1, 0,  0, 64,   1,  0, 2, 0};
        vecs[8]  = '{1, 100,  0, 0, 2'b00, 0, 1,  0, 64,   0,  0, 2, 1};
        vecs[9]  = '{1, 100,  0, 0, 2'b00, 0, 0,  1, 100,  0,  0, 2, 1};
        vecs[10] = '{1, 100,  0, 1, 2'b00, 1, 1,  1, 100,  0,  0, 0, 0};
        vecs[11] = '{1, 100,  0, 0, 2'b00, 1, 1,  1, 100,  0,  0, 1, 1};
        vecs[12] = '{1, 100,  1, 0, 2'b00, 0, 0,  1, 100,  0,  0, 1, 1};
        foreach (vecs[i]) begin
            set_in(vecs[i].en, vecs[i].len, vecs[i].fclr, vecs[i].cclr,
                   vecs[i].start, vecs[i].good, vecs[i].bad);
            step();
            chk($sformatf("vec%0d_cfg_en", i), 32'(ifc.cfg_rx_enable), 32'(vecs[i].ce));
            chk($sformatf("vec%0d_len", i), 32'(ifc.cfg_rx_max_pkt_len), 32'(vecs[i].ml));
            chk($sformatf("vec%0d_busy", i), 32'(rx_busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].flt));
            chk($sformatf("vec%0d_good", i), 32'(good_cnt), 32'(vecs[i].gc));
            chk($sformatf("vec%0d_bad", i), 32'(bad_cnt), 32'(vecs[i].bc));
        end

        // Eight bad frames inside one window trip the fault
        align(0);
        for (int i = 0; i < THRESH; i++) begin
            set_in(1, 1518, 0, 0, 0, 0, 1);
            step();
            if (i == THRESH - 2) chk("fault_before_thresh", 32'(fault), 0);
        end
        chk("fault_at_thresh", 32'(fault), 1);
        chk("fault_cfg_en", 32'(ifc.cfg_rx_enable), 0);
        set_in(1, 1518, 1, 0, 0, 0, 0);
        step();
        chk("fault_cleared", 32'(fault), 0);
        chk("cleared_disabled", 32'(ifc.cfg_rx_enable), 0);
        set_in(1, 1518, 0, 0, 0, 0, 0);
        step();
        chk("reenable", 32'(ifc.cfg_rx_enable), 1);

        // Seven bad, wrap-cycle bad, six more: seven per window, no trip; one more trips
        align(WIN - THRESH);
        for (int i = 0; i < THRESH - 1; i++) begin
            set_in(1, 1518, 0, 0, 0, 0, 1);
            step();
        end
        chk("win_first7", 32'(fault), 0);
        chk("win_wrap_phase", 32'(m_act % WIN), 32'(WIN - 1));
        for (int i = 0; i < THRESH - 1; i++) begin
            set_in(1, 1518, 0, 0, 0, 0, 1);
            step();
        end
        chk("win_second7_nofault", 32'(fault), 0);
        set_in(1, 1518, 0, 0, 0, 0, 1);
        step();
        chk("win_wrap_counted", 32'(fault), 1);

        // Asynchronous reset mid-frame with counters at 5/3
        set_in(1, 1518, 1, 0, 0, 0, 0); step();
        set_in(1, 1518, 0, 1, 0, 0, 0); step();
        for (int i = 0; i < 5; i++) begin set_in(1, 1518, 0, 0, 2'b01, 1, 0); step(); end
        for (int i = 0; i < 3; i++) begin set_in(1, 1518, 0, 0, 2'b01, 0, 1); step(); end
        chk("pre_rst_good", 32'(good_cnt), 5);
        chk("pre_rst_bad", 32'(bad_cnt), 3);
        chk("pre_rst_busy", 32'(rx_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        set_in(0, 1518, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        set_in(0, 1518, 0, 0, 0, 1, 0);
        step();
        chk("post_rst_good_counted", 32'(good_cnt), 1);
        chk("post_rst_no_busy", 32'(rx_busy), 0);

        // Random traffic against the model
        en = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(31) == 0) en = ~en;
            len   = 16'($urandom_range(9600, 64));
            start = ($urandom_range(5) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            good  = ($urandom_range(7) == 0);
            bad   = ($urandom_range((n < 2000) ? 15 : 2) == 0);
            fclr  = ($urandom_range(39) == 0);
            cclr  = ($urandom_range(199) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
